// File: rtl/dsr_phase_sequencer.sv
// Clock-enable sequencer for the two-stage decimating filter: tracks the DSR1 x DSR2
// sample phase, issues write slots and enable pulses, and gates output during warm-up.
module dsr_phase_sequencer #(
  parameter int DSR1       = 2,
  parameter int DSR2       = 6,
  parameter int FILL_DEPTH = 13,
  parameter int PIPE_DELAY = 2,
  parameter int SLOT_W     = (DSR1*DSR2 > 1) ? $clog2(DSR1*DSR2) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              in_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_we,
  output logic              ce_recurse,
  output logic              ce_ds,
  output logic              compute_en,
  output logic              valid,
  output logic [1:0]        state
);

  localparam int DSR    = DSR1 * DSR2;
  localparam int DS_MAX = (FILL_DEPTH > PIPE_DELAY) ? FILL_DEPTH : PIPE_DELAY;
  localparam int DS_W   = $clog2(DS_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PRIME = 2'd2, RUN = 2'd3} state_t;

  state_t            st, st_nxt;
  logic [SLOT_W-1:0] cnt1, cnt2;
  logic [DS_W-1:0]   ds_cnt;
  logic              accept, rec_done, frame_done;

  assign accept     = in_valid & run & ~rst;
  assign slot_we    = accept;
  assign slot       = cnt1 + SLOT_W'(cnt2 * DSR1);
  assign rec_done   = accept && (cnt1 == SLOT_W'(DSR1 - 1));
  assign frame_done = accept && (slot == SLOT_W'(DSR - 1));
  assign state      = st;

  // run low overrides every transition; warm-up always restarts from FILL
  always_comb begin
    st_nxt = st;
    if (!run) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:  st_nxt = FILL;
        FILL:  if (frame_done && ds_cnt == DS_W'(FILL_DEPTH - 1))
                 st_nxt = (PIPE_DELAY == 0) ? RUN : PRIME;
        PRIME: if (frame_done && ds_cnt == DS_W'(PIPE_DELAY - 1))
                 st_nxt = RUN;
        RUN:   st_nxt = RUN;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      cnt1       <= '0;
      cnt2       <= '0;
      ds_cnt     <= '0;
      ce_recurse <= 1'b0;
      ce_ds      <= 1'b0;
      compute_en <= 1'b0;
      valid      <= 1'b0;
    end else begin
      st         <= st_nxt;
      ce_recurse <= rec_done;
      ce_ds      <= frame_done;
      compute_en <= (st_nxt == PRIME) || (st_nxt == RUN);
      valid      <= (st_nxt == RUN);

      // ratio-1 counters collapse to constant 0 through the wrap compare
      if (!run) begin
        cnt1 <= '0;
        cnt2 <= '0;
      end else if (accept) begin
        if (cnt1 == SLOT_W'(DSR1 - 1)) begin
          cnt1 <= '0;
          cnt2 <= (cnt2 == SLOT_W'(DSR2 - 1)) ? '0 : cnt2 + 1'b1;
        end else begin
          cnt1 <= cnt1 + 1'b1;
        end
      end

      if (!run || st_nxt != st)
        ds_cnt <= '0;
      else if (frame_done && (st == FILL || st == PRIME))
        ds_cnt <= ds_cnt + 1'b1;
    end
  end

endmodule

// File: doc/dsr_phase_sequencer.md
Name: dsr_phase_sequencer

Overview:
- Single-clock sequencer that replaces the derived-clock scheme of the hybrid cumulative fixed-point filter with clock enables.
- Tracks the two-stage decimation phase (DSR1 × DSR2) of accepted input samples.
- Emits the sample-word write slot, the recursion and downsample clock-enable pulses, and the warm-up gating (compute enable, output valid).
- Sits between the modulator input interface and the filter datapath. All datapath registers run on clk, qualified by its enables.

Parameters:
DSR1, 2, first-stage decimation ratio (≥1); recursion-LUT enable period in accepted samples
DSR2, 6, second-stage decimation ratio (≥1); DSR = DSR1*DSR2
FILL_DEPTH, 13, downsampled frames needed to fill the lookahead shift register (≥1)
PIPE_DELAY, 2, extra frames of datapath pipeline latency before output is valid (≥0)
SLOT_W, max(1,$clog2(DSR1*DSR2)), width of slot index

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
run  in  1  sequencer enable; low forces IDLE
in_valid  in  1  input sample present this cycle
slot  out  SLOT_W  write position of current sample in the sample word, = cnt1 + cnt2*DSR1
slot_we  out  1  combinational, = in_valid & run & !rst; write in at slot
ce_recurse  out  1  one-cycle pulse, registered; recursion-stage enable
ce_ds  out  1  one-cycle pulse, registered; downsampled-stage enable / shift-register load
compute_en  out  1  gate for recursion inputs (zero-forcing before fill complete)
valid  out  1  filter output valid
state  out  2  IDLE=0, FILL=1, PRIME=2, RUN=3

Behaviour:
- accept = in_valid & run & !rst.
- Counters: cnt1 ∈ [0,DSR1-1] and cnt2 ∈ [0,DSR2-1] advance only on accept.
  - cnt1 wraps to 0 and increments cnt2; cnt2 wraps to 0.
  - DSR1=1 or DSR2=1 makes the corresponding counter a constant 0.
- Frame events:
  - rec_done = accept & cnt1==DSR1-1.
  - frame_done = accept & slot==DSR-1.
- ce_recurse <= rec_done; ce_ds <= frame_done. Each is high exactly 1 cycle, the cycle after the triggering accept.
- No accept means counters hold and no pulses. in_valid gaps stretch frames and never skip slots.
- ds_cnt counts frame_done events in FILL and PRIME, and clears on every state change.
- State transitions, registered on the frame_done edge:
  - IDLE→FILL when run=1; ds_cnt=0; counters start at 0.
  - FILL→PRIME when frame_done & ds_cnt==FILL_DEPTH-1. Goes to RUN directly if PIPE_DELAY=0.
  - PRIME→RUN when frame_done & ds_cnt==PIPE_DELAY-1.
  - RUN holds until run=0 or rst.
- Outputs by state:
  - compute_en = state∈{PRIME,RUN}.
  - valid = state==RUN.
  - Both are registered; they change in the same cycle as the corresponding ce_ds pulse.
- run deasserted in any state: next cycle state=IDLE, counters and ds_cnt cleared, compute_en=valid=ce_*=0. On re-run a full FILL_DEPTH+PIPE_DELAY warm-up is required.
- rst has priority over run and in_valid. Next cycle: state=IDLE, cnt1=cnt2=ds_cnt=0, ce_recurse=ce_ds=compute_en=valid=0, slot=0. slot_we is 0 while rst=1.
- in_valid in IDLE (run=0) is ignored: no slot advance, slot_we=0.
- Simultaneous frame_done and run falling: run=0 wins. No pulse is emitted and the state goes to IDLE.

Test Plan:
1. Reset: rst=1 for 3 cycles with run=1, in_valid=1 -> all outputs 0, state=0, slot_we=0; slot=0 on the cycle after rst falls.
2. Defaults, run=1, in_valid continuous from cycle 0 -> slot 0..11 repeating; ce_recurse high at cycles 2,4,6,…; ce_ds high at cycles 12,24,…; compute_en rises at cycle 156 (13th ce_ds, state=2); valid rises at cycle 180 (state=3).
3. in_valid high on even cycles only -> accepts at 0,2,…; first ce_ds at cycle 23; slot never skips a value; no ce pulses on idle cycles.
4. In RUN, run=0 for 1 cycle, then run=1 -> state=0, valid=0, compute_en=0 the next cycle; valid re-rises 180 accepted samples after restart.
5. rst=1 asserted in the same cycle as a frame_done in PRIME -> no ce_ds pulse; state=0 and ds_cnt=0 next cycle.
6. DSR1=1, DSR2=4, FILL_DEPTH=2, PIPE_DELAY=0, continuous input -> ce_recurse every cycle from cycle 1; ce_ds at 4,8; compute_en and valid rise together at cycle 8.
